// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: operand word width, ALU opcode encoding and
// the switch-to-word sign extension used by the operand loader.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned SW_W   = 17;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'h0,
        ALU_SUB   = 4'h1,
        ALU_AND   = 4'h2,
        ALU_OR    = 4'h3,
        ALU_XOR   = 4'h4,
        ALU_NOR   = 4'h5,
        ALU_SLL   = 4'h6,
        ALU_SRL   = 4'h7,
        ALU_SRA   = 4'h8,
        ALU_SLT   = 4'h9,
        ALU_SLTU  = 4'hA,
        ALU_LUI   = 4'hB,
        ALU_PASSA = 4'hC,
        ALU_PASSB = 4'hD,
        ALU_MUL   = 4'hE,
        ALU_NOP   = 4'hF
    } aluop_t;

    // sw[16] replicates across the upper half of the operand word.
    function automatic logic [WORD_W-1:0] sw_ext(input logic [SW_W-1:0] s);
        return {{(WORD_W-16){s[16]}}, s[15:0]};
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus counter debouncer for one active-low push button;
// press is a one-cycle pulse on the debounced 1->0 transition.
module key_debounce #(
    parameter int unsigned DB_CYCLES = 250000
) (
    input  logic CLK,
    input  logic RST,
    input  logic key_n,
    output logic level,
    output logic press
);

    logic        sync1;
    logic        sync2;
    logic [19:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == 20'(DB_CYCLES - 1)) begin
                // DB_CYCLES-th consecutive differing cycle: accept the new level
                level <= sync2;
                cnt   <= '0;
                press <= ~sync2;
            end else begin
                cnt <= cnt + 20'd1;
            end
        end
    end

endmodule

// File: rtl/alu_operand_loader.sv
// Switch/button operand entry for the ALU: A, B, opcode, then valid/ready handoff.
// Optional 7-segment echo output enabled by LOADER_ECHO_EN.
module alu_operand_loader
    import cpu_types_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 250000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [SW_W-1:0]   sw,
    input  logic [1:0]        key_n,
    input  logic              op_ready,
    output logic [WORD_W-1:0] porta,
    output logic [WORD_W-1:0] portb,
    output aluop_t            aluop,
    output logic              op_valid,
    output logic [3:0]        stage,
    output logic [7:0]        xfer_cnt
`ifdef LOADER_ECHO_EN
    ,
    output logic [WORD_W-1:0] echo
`endif
);

    typedef enum logic [1:0] {
        S_A     = 2'd0,
        S_B     = 2'd1,
        S_OP    = 2'd2,
        S_VALID = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [WORD_W-1:0] porta_nxt, portb_nxt;
    aluop_t            aluop_nxt;
    logic [7:0]        xfer_cnt_nxt;
    logic              enter_press, clear_press;
    logic [1:0]        key_level_unused;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_enter (
        .CLK   (CLK),
        .RST   (RST),
        .key_n (key_n[0]),
        .level (key_level_unused[0]),
        .press (enter_press)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_clear (
        .CLK   (CLK),
        .RST   (RST),
        .key_n (key_n[1]),
        .level (key_level_unused[1]),
        .press (clear_press)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_A;
            porta    <= '0;
            portb    <= '0;
            aluop    <= aluop_t'(4'd0);
            xfer_cnt <= '0;
        end else begin
            state    <= state_nxt;
            porta    <= porta_nxt;
            portb    <= portb_nxt;
            aluop    <= aluop_nxt;
            xfer_cnt <= xfer_cnt_nxt;
        end
    end

    // Clear outranks a same-cycle transfer, which outranks enter.
    always_comb begin
        state_nxt    = state;
        porta_nxt    = porta;
        portb_nxt    = portb;
        aluop_nxt    = aluop;
        xfer_cnt_nxt = xfer_cnt;
        if (clear_press) begin
            state_nxt = S_A;
            porta_nxt = '0;
            portb_nxt = '0;
            aluop_nxt = aluop_t'(4'd0);
        end else begin
            unique case (state)
                S_A: if (enter_press) begin
                    porta_nxt = sw_ext(sw);
                    state_nxt = S_B;
                end
                S_B: if (enter_press) begin
                    portb_nxt = sw_ext(sw);
                    state_nxt = S_OP;
                end
                S_OP: if (enter_press) begin
                    aluop_nxt = aluop_t'(sw[3:0]);
                    state_nxt = S_VALID;
                end
                S_VALID: if (op_ready) begin
                    xfer_cnt_nxt = xfer_cnt + 8'd1;
                    state_nxt    = S_A;
                end
                default: state_nxt = S_A;
            endcase
        end
    end

    always_comb begin
        op_valid = (state == S_VALID);
        stage    = 4'b0001 << state;
    end

`ifdef LOADER_ECHO_EN
    always_comb begin
        echo = porta;
        unique case (state)
            S_A, S_B: echo = sw_ext(sw);
            S_OP:     echo = {{(WORD_W-4){1'b0}}, sw[3:0]};
            default:  echo = porta;
        endcase
    end
`endif

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader (DB_CYCLES=4) with a history-based
// behavioural model compared every cycle plus literal spot checks.
module tb_alu_operand_loader;
    import cpu_types_pkg::*;

    localparam int unsigned DB = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic [16:0] sw;
    logic [1:0]  key_n;
    logic        op_ready;
    logic [31:0] porta, portb;
    aluop_t      aluop;
    logic        op_valid;
    logic [3:0]  stage;
    logic [7:0]  xfer_cnt;
`ifdef LOADER_ECHO_EN
    logic [31:0] echo;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    alu_operand_loader #(.DB_CYCLES(DB)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .sw       (sw),
        .key_n    (key_n),
        .op_ready (op_ready),
        .porta    (porta),
        .portb    (portb),
        .aluop    (aluop),
        .op_valid (op_valid),
        .stage    (stage),
        .xfer_cnt (xfer_cnt)
`ifdef LOADER_ECHO_EN
        ,
        .echo     (echo)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ext(input logic [16:0] s);
        return {{16{s[16]}}, s[15:0]};
    endfunction

    // Model: raw key samples history, debounced level, one-cycle press, loader state.
    logic [1:0]  hist [DB+1];
    logic [1:0]  mdeb, mpress;
    int          mst;
    logic [31:0] ma, mb;
    logic [3:0]  mop;
    logic [7:0]  mcnt;
    bit          mvalid = 1'b0;

    always @(posedge CLK) begin
        bit   same;
        logic v;
        if (RST) begin
            for (int j = 0; j <= DB; j++) hist[j] = 2'b11;
            mdeb   = 2'b11;
            mpress = 2'b00;
            mst    = 0;
            ma     = '0;
            mb     = '0;
            mop    = '0;
            mcnt   = '0;
            mvalid = 1'b1;
        end else begin
            if (mpress[1]) begin
                ma = '0; mb = '0; mop = '0; mst = 0;
            end else if (mst == 3 && op_ready) begin
                mst  = 0;
                mcnt = mcnt + 8'd1;
            end else if (mpress[0]) begin
                case (mst)
                    0: begin ma  = ext(sw);  mst = 1; end
                    1: begin mb  = ext(sw);  mst = 2; end
                    2: begin mop = sw[3:0];  mst = 3; end
                    default: ;
                endcase
            end
            // Debounced level follows a raw level seen at DB consecutive samples,
            // delayed by the two synchronizer stages.
            for (int k = 0; k < 2; k++) begin
                same = 1'b1;
                v    = hist[1][k];
                for (int j = 2; j <= DB; j++) if (hist[j][k] != v) same = 1'b0;
                mpress[k] = 1'b0;
                if (same && v != mdeb[k]) begin
                    mdeb[k]   = v;
                    mpress[k] = (v == 1'b0);
                end
            end
            for (int j = DB; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = key_n;
        end
    end

    always @(negedge CLK) begin
        if (mvalid) begin
            check("porta",    porta,               ma);
            check("portb",    portb,               mb);
            check("aluop",    32'(aluop),          32'(mop));
            check("op_valid", 32'(op_valid),       32'(mst == 3));
            check("stage",    32'(stage),          32'(4'b0001 << mst));
            check("xfer_cnt", 32'(xfer_cnt),       32'(mcnt));
`ifdef LOADER_ECHO_EN
            check("echo", echo, (mst == 3) ? ma : (mst == 2) ? {28'b0, sw[3:0]} : ext(sw));
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic press(input logic [1:0] keys);
        key_n = ~keys;
        tick(DB + 4);
        key_n = 2'b11;
        tick(DB + 4);
    endtask

    task automatic load(input logic [16:0] a, input logic [16:0] b, input logic [3:0] op);
        sw = a;             press(2'b01);
        sw = b;             press(2'b01);
        sw = {13'b0, op};   press(2'b01);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1);
    end

    initial begin
        RST = 1'b1; sw = '0; key_n = 2'b11; op_ready = 1'b0;
        tick(3);
        RST = 1'b0;
        tick(1);
        check("rst_stage", 32'(stage), 32'h1);
        check("rst_porta", porta, 32'h0);
        check("rst_xfer",  32'(xfer_cnt), 32'h0);

        // 3-cycle glitch on enter
        key_n[0] = 1'b0; tick(3); key_n[0] = 1'b1; tick(10);
        check("glitch_stage", 32'(stage), 32'h1);

        sw = 17'h1FFFE; press(2'b01);
        check("entry_porta", porta, 32'hFFFFFFFE);
        check("entry_stage_b", 32'(stage), 32'h2);
        sw = 17'h00003; press(2'b01);
        check("entry_portb", portb, 32'h00000003);

        // Press lands in cycle 2+DB; op_valid follows one cycle later.
        sw = 17'h00002; key_n[0] = 1'b0;
        tick(6);
        check("ov_before_press", 32'(op_valid), 32'h0);
        tick(1);
        check("ov_after_press", 32'(op_valid), 32'h1);
        check("entry_aluop", 32'(aluop), 32'h2);
        key_n = 2'b11; tick(DB + 4);

        op_ready = 1'b0; tick(10);
        sw = 17'h0ABCD; press(2'b01);
        check("bp_valid", 32'(op_valid), 32'h1);
        check("bp_porta", porta, 32'hFFFFFFFE);
        check("bp_portb", portb, 32'h00000003);
        check("bp_aluop", 32'(aluop), 32'h2);
        op_ready = 1'b1; tick(1); op_ready = 1'b0;
        check("xfer_stage", 32'(stage), 32'h1);
        check("xfer_cnt1", 32'(xfer_cnt), 32'h1);
        check("xfer_hold_a", porta, 32'hFFFFFFFE);

        // Clear press coincident with op_ready in S_VALID
        load(17'h00010, 17'h00020, 4'h3);
        key_n[1] = 1'b0;
        tick(6);
        check("pre_clear_valid", 32'(stage), 32'h8);
        op_ready = 1'b1; tick(1); op_ready = 1'b0;
        check("clr_stage", 32'(stage), 32'h1);
        check("clr_porta", porta, 32'h0);
        check("clr_portb", portb, 32'h0);
        check("clr_aluop", 32'(aluop), 32'h0);
        check("clr_xfer",  32'(xfer_cnt), 32'h1);
        key_n = 2'b11; tick(DB + 4);

        sw = 17'h00055; press(2'b01);
        check("both_pre", porta, 32'h00000055);
        sw = 17'h00066; press(2'b11);
        check("both_stage", 32'(stage), 32'h1);
        check("both_porta", porta, 32'h0);

        sw = 17'h1FFFE; press(2'b01);
        sw = 17'h00007; press(2'b01);
        check("rst_op_pre", 32'(stage), 32'h4);
        RST = 1'b1; tick(1); RST = 1'b0;
        check("rst_op_stage", 32'(stage), 32'h1);
        check("rst_op_porta", porta, 32'h0);
        check("rst_op_portb", portb, 32'h0);
        check("rst_op_aluop", 32'(aluop), 32'h0);
        check("rst_op_xfer",  32'(xfer_cnt), 32'h0);
        check("rst_op_valid", 32'(op_valid), 32'h0);

`ifdef LOADER_ECHO_EN
        sw = 17'h10005; tick(1);
        check("echo_sa", echo, 32'hFFFF0005);
`endif

        for (int i = 0; i < 256; i++) begin
            load(17'(i * 3), 17'(i + 17'h10000), 4'(i));
            op_ready = 1'b1; tick(1); op_ready = 1'b0;
            if (i == 254) check("wrap_255", 32'(xfer_cnt), 32'hFF);
        end
        check("wrap_0", 32'(xfer_cnt), 32'h0);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_operand_loader.md
ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

Interface
REQ-001 Parameter: DB_CYCLES, default 250000, number of consecutive stable cycles required before a debounced key level changes (legal range 1 to 2^20-1).
REQ-002 Port: CLK  input  1  single clock for all logic.
REQ-003 Port: RST  input  1  reset, synchronous, active-high.
REQ-004 Port: sw  input  17  raw switches; sw[15:0] data, sw[16] sign/extend bit.
REQ-005 Port: key_n  input  2  raw push buttons, active-low, asynchronous to CLK; key_n[0] = enter, key_n[1] = clear.
REQ-006 Port: op_ready  input  1  downstream ALU stage accepts the operand set.
REQ-007 Port: porta  output  32  operand A to ALU.
REQ-008 Port: portb  output  32  operand B to ALU.
REQ-009 Port: aluop  output  4  ALU opcode, of type aluop_t.
REQ-010 Port: op_valid  output  1  operand set complete and held stable.
REQ-011 Port: stage  output  4  one-hot FSM state for LEDs; bit 0 = S_A, 1 = S_B, 2 = S_OP, 3 = S_VALID.
REQ-012 Port: xfer_cnt  output  8  count of completed handshakes.

Function
REQ-013 Each key_n bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Per key: a counter clears whenever the synchronized level equals the debounced level; after DB_CYCLES consecutive differing cycles, the debounced level SHALL take the synchronized value.
REQ-015 A press SHALL be a one-cycle pulse on a debounced 1->0 transition; with raw key held low from cycle 0, the pulse SHALL occur exactly in cycle 2+DB_CYCLES.
REQ-016 Glitches shorter than DB_CYCLES cycles SHALL produce no press.
REQ-017 Extension: ext(sw) = {16{sw[16]}, sw[15:0]}.
REQ-018 FSM states: S_A, S_B, S_OP, S_VALID.
REQ-019 S_A, enter press: porta <= ext(sw), next state S_B.
REQ-020 S_B, enter press: portb <= ext(sw), next state S_OP.
REQ-021 S_OP, enter press: aluop <= sw[3:0], next state S_VALID.
REQ-022 op_valid SHALL be 1 exactly while in S_VALID, asserting the cycle after the S_OP enter press.
REQ-023 Transfer: op_valid && op_ready at a rising edge; next state S_A, and xfer_cnt increments, wrapping 255->0.
REQ-024 Enter presses in S_VALID SHALL be ignored.
REQ-025 porta, portb and aluop SHALL hold unchanged while op_valid=1 and after transfer until overwritten.
REQ-026 Clear press in any state: porta, portb and aluop <= 0, next state S_A; xfer_cnt unchanged.
REQ-027 Clear has priority over enter and over a same-cycle transfer; in that case xfer_cnt SHALL NOT increment.
REQ-028 op_ready while not in S_VALID SHALL have no effect.

Reset
REQ-029 On RST=1 at a rising edge: state S_A (stage=4'b0001), porta=0, portb=0, aluop=0, op_valid=0, xfer_cnt=0, debounced levels=1, debounce counters=0, synchronizers=1.
REQ-030 Reset mid-entry or mid-handshake SHALL discard all partial entry, with no transfer counted.

Configuration
REQ-031 Macro LOADER_ECHO_EN SHALL be the only compile option.
REQ-032 With LOADER_ECHO_EN defined, an extra output echo (32 bits, combinational from registered state) SHALL be present; it is ext(sw) in S_A and S_B, {28'b0, sw[3:0]} in S_OP, and porta in S_VALID, for driving the 7-segment display.
REQ-033 With LOADER_ECHO_EN undefined, the echo port and its logic SHALL be absent, and all other behaviour is identical.

Structure
REQ-034 aluop_t and WORD_W=32 SHALL come from cpu_types_pkg; the loader state enum SHALL be local to the module.
REQ-035 The synchronizer plus debounce logic SHALL be one sub-module, key_debounce (parameter DB_CYCLES; outputs level and press), instantiated once per key.

Verification (bench uses DB_CYCLES=4)
REQ-036 Glitch rejection: key_n[0] low for 3 cycles -> no press, stage stays 4'b0001.
REQ-037 Full entry:
- sw=17'h1FFFE, then enter -> porta=32'hFFFFFFFE.
- sw=17'h00003, then enter -> portb=32'h00000003.
- sw[3:0]=4'h2, then enter -> aluop=4'h2, op_valid=1 one cycle after the press.
REQ-038 Backpressure and transfer:
- op_ready=0 for 10 cycles -> op_valid stays 1, outputs stable, extra enter presses ignored.
- op_ready=1 -> stage=4'b0001 and xfer_cnt=1 on the next cycle.
REQ-039 Clear/enter/transfer collision:
- In S_VALID, a clear press coincident with op_ready=1 -> S_A, porta=portb=aluop=0, xfer_cnt unchanged.
- Enter and clear pulses in the same cycle -> clear wins.
REQ-040 Wrap-around: 256 complete transfers -> xfer_cnt=0.
REQ-041 Reset in S_OP:
- Assert RST -> all outputs at their reset values on the next cycle.
- With LOADER_ECHO_EN defined and sw=17'h10005 in S_A -> echo=32'hFFFF0005.
